// File: rtl/axi_hs_pkg.sv
// Shared types and sizing helpers for the AXI VALID/READY handshake demonstrator.
// The optional register slice is built when AXI_HS_REG_SLICE_EN is defined.
package axi_hs_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_READY_PERIOD = 2;

  typedef logic [DEF_DATA_W-1:0] data_t;

  // Index width for a modulo-depth counter; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_hs_source.sv
// Source stage: FIFO buffering strobed words and presenting the head entry with VALID.
// Built identically with or without AXI_HS_REG_SLICE_EN; only its ready input source changes.
module axi_hs_source
  import axi_hs_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              valid_r;
  logic              pop_s;
  logic              push_ok_s;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_s     = valid_r && ready;
  assign push_ok_s = push && ((count_r < DEPTH_C) || pop_s);
  assign valid     = valid_r;
  assign data      = mem_r[rd_ptr_r];

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy; valid tracks a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
    end
  end

endmodule

// File: rtl/axi_handshake_top.sv
// AXI VALID/READY demonstrator: FIFO source feeding a throttled sink that registers data_out.
// Define AXI_HS_REG_SLICE_EN to insert a 2-entry skid register slice between source and sink.
module axi_handshake_top
  import axi_hs_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int READY_PERIOD = DEF_READY_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int RP_W = ptr_width(READY_PERIOD);
  localparam logic [RP_W-1:0] RP_LAST_C = RP_W'(READY_PERIOD - 1);
  localparam logic [RP_W-1:0] RP_ONE_C  = RP_W'(1);
  localparam logic            RDY_RST_C = (READY_PERIOD == 1);

  logic              src_valid_s;
  logic              src_ready_s;
  logic [DATA_W-1:0] src_data_s;
  logic              sink_valid_s;
  logic [DATA_W-1:0] sink_data_s;
  logic [RP_W-1:0]   thr_cnt_r;
  logic [RP_W-1:0]   thr_cnt_nxt_s;
  logic              ready_r;
  logic [DATA_W-1:0] data_out_r;

  axi_hs_source #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_src (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (en),
    .push_data (data_in),
    .ready     (src_ready_s),
    .valid     (src_valid_s),
    .data      (src_data_s)
  );

`ifdef AXI_HS_REG_SLICE_EN
  logic              slc_in_ready_r;
  logic              slc_out_valid_r;
  logic [DATA_W-1:0] slc_out_data_r;
  logic              slc_skid_valid_r;
  logic [DATA_W-1:0] slc_skid_data_r;
  logic              slc_out_valid_nxt_s;
  logic [DATA_W-1:0] slc_out_data_nxt_s;
  logic              slc_skid_valid_nxt_s;
  logic [DATA_W-1:0] slc_skid_data_nxt_s;
  logic              slc_in_acc_s;

  assign slc_in_acc_s = src_valid_s && slc_in_ready_r;
  assign src_ready_s  = slc_in_ready_r;
  assign sink_valid_s = slc_out_valid_r;
  assign sink_data_s  = slc_out_data_r;

  // Skid next state; a held skid entry always drains before new input is taken.
  always_comb begin
    slc_out_valid_nxt_s  = slc_out_valid_r;
    slc_out_data_nxt_s   = slc_out_data_r;
    slc_skid_valid_nxt_s = slc_skid_valid_r;
    slc_skid_data_nxt_s  = slc_skid_data_r;
    if (!slc_out_valid_r || ready_r) begin
      if (slc_skid_valid_r) begin
        slc_out_valid_nxt_s  = 1'b1;
        slc_out_data_nxt_s   = slc_skid_data_r;
        slc_skid_valid_nxt_s = 1'b0;
      end else begin
        slc_out_valid_nxt_s = slc_in_acc_s;
        slc_out_data_nxt_s  = slc_in_acc_s ? src_data_s : slc_out_data_r;
      end
    end else begin
      if (slc_in_acc_s) begin
        slc_skid_valid_nxt_s = 1'b1;
        slc_skid_data_nxt_s  = src_data_s;
      end else begin
        slc_skid_valid_nxt_s = slc_skid_valid_r;
      end
    end
  end

  // Slice registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slc_in_ready_r   <= 1'b1;
      slc_out_valid_r  <= 1'b0;
      slc_out_data_r   <= '0;
      slc_skid_valid_r <= 1'b0;
      slc_skid_data_r  <= '0;
    end else begin
      slc_in_ready_r   <= !slc_skid_valid_nxt_s;
      slc_out_valid_r  <= slc_out_valid_nxt_s;
      slc_out_data_r   <= slc_out_data_nxt_s;
      slc_skid_valid_r <= slc_skid_valid_nxt_s;
      slc_skid_data_r  <= slc_skid_data_nxt_s;
    end
  end
`else
  assign src_ready_s  = ready_r;
  assign sink_valid_s = src_valid_s;
  assign sink_data_s  = src_data_s;
`endif

  // Free-running mod-READY_PERIOD counter.
  always_comb begin
    if (thr_cnt_r == RP_LAST_C) begin
      thr_cnt_nxt_s = '0;
    end else begin
      thr_cnt_nxt_s = thr_cnt_r + RP_ONE_C;
    end
  end

  // Ready is registered as the decode of the counter's next value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_cnt_r <= '0;
      ready_r   <= RDY_RST_C;
    end else begin
      thr_cnt_r <= thr_cnt_nxt_s;
      ready_r   <= (thr_cnt_nxt_s == RP_LAST_C);
    end
  end

  // Sink capture on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_r <= '0;
    end else if (sink_valid_s && ready_r) begin
      data_out_r <= sink_data_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_axi_handshake_top.sv
// Directed bench for axi_handshake_top with READY_PERIOD 1, 2 and 8 instances on shared stimulus.
module tb_axi_handshake_top;

`ifdef AXI_HS_REG_SLICE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] data_in;
  logic [31:0] out_rp1;
  logic [31:0] out_rp2;
  logic [31:0] out_rp8;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_rp1[$];
  logic [31:0] q_rp2[$];
  logic [31:0] q_rp8[$];
  logic [31:0] prev_rp1 = 32'd0;
  logic [31:0] prev_rp2 = 32'd0;
  logic [31:0] prev_rp8 = 32'd0;

  always #5 clk = ~clk;

  axi_handshake_top #(.DATA_W(32), .FIFO_DEPTH(4), .READY_PERIOD(1)) u_rp1 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .data_out(out_rp1));
  axi_handshake_top #(.DATA_W(32), .FIFO_DEPTH(4), .READY_PERIOD(2)) u_rp2 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .data_out(out_rp2));
  axi_handshake_top #(.DATA_W(32), .FIFO_DEPTH(4), .READY_PERIOD(8)) u_rp8 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .data_out(out_rp8));

  // Record each new nonzero data_out value per instance.
  always @(negedge clk) begin
    if (out_rp1 !== prev_rp1 && out_rp1 != 32'd0) q_rp1.push_back(out_rp1);
    if (out_rp2 !== prev_rp2 && out_rp2 != 32'd0) q_rp2.push_back(out_rp2);
    if (out_rp8 !== prev_rp8 && out_rp8 != 32'd0) q_rp8.push_back(out_rp8);
    prev_rp1 <= out_rp1;
    prev_rp2 <= out_rp2;
    prev_rp8 <= out_rp8;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; also checks AXI stability on the slow instance's source.
  task automatic tick;
    logic        pv;
    logic        pr;
    logic        pre_rst;
    logic [31:0] pd;
    pv      = u_rp8.src_valid_s;
    pr      = u_rp8.src_ready_s;
    pd      = u_rp8.src_data_s;
    pre_rst = rst_n;
    @(posedge clk);
    #1;
    if (pv && !pr && pre_rst) begin
      check("hold_valid", {31'd0, u_rp8.src_valid_s}, 32'd1);
      check("hold_data", u_rp8.src_data_s, pd);
    end
  endtask

  initial begin
    logic [31:0] exp_p2 [4];
    logic [31:0] exp_p8 [4];
    exp_p2[0] = 32'd55; exp_p2[1] = 32'd57; exp_p2[2] = 32'd60; exp_p2[3] = 32'd64;
    exp_p8[0] = 32'd1;  exp_p8[1] = 32'd2;  exp_p8[2] = 32'd3;  exp_p8[3] = 32'd4;

    // Reset with en asserted: nothing may be captured.
    rst_n = 1'b0; en = 1'b1; data_in = 32'd77;
    repeat (5) tick();
    check("rst_out_rp1", out_rp1, 32'd0);
    check("rst_out_rp2", out_rp2, 32'd0);
    check("rst_out_rp8", out_rp8, 32'd0);
    check("rst_valid_rp1", {31'd0, u_rp1.src_valid_s}, 32'd0);
    check("rst_valid_rp8", {31'd0, u_rp8.src_valid_s}, 32'd0);
    check("rst_count_rp8", 32'(u_rp8.u_src.count_r), 32'd0);

    // Always-ready sink: single word latency and hold.
    rst_n = 1'b1; en = 1'b1; data_in = 32'd55;
    tick();
    en = 1'b0; data_in = 32'd0;
    repeat (LAT - 1) tick();
    check("lat_no_bypass", out_rp1, 32'd0);
    tick();
    check("lat_first", out_rp1, 32'd55);
    repeat (3) tick();
    check("lat_hold", out_rp1, 32'd55);

    // READY_PERIOD=2 with interleaved non-strobed words.
    rst_n = 1'b0; en = 1'b0;
    repeat (2) tick();
    q_rp1.delete(); q_rp2.delete(); q_rp8.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      data_in = 32'(55 + i);
      en = ((55 + i) inside {55, 57, 60, 64});
      tick();
    end
    en = 1'b0;
    repeat (12) tick();
    check("p2_len", 32'(q_rp2.size()), 32'd4);
    check("p1_len", 32'(q_rp1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("p2_seq", (i < q_rp2.size()) ? q_rp2[i] : 32'hDEAD_BEEF, exp_p2[i]);
      check("p1_seq", (i < q_rp1.size()) ? q_rp1[i] : 32'hDEAD_BEEF, exp_p2[i]);
    end

    // READY_PERIOD=8: fifth word arrives while full and is dropped.
    rst_n = 1'b0;
    repeat (2) tick();
    q_rp8.delete();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      en = 1'b1; data_in = 32'(i);
      tick();
    end
    en = 1'b0; data_in = 32'd0;
    repeat (40) tick();
    check("p8_len", 32'(q_rp8.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("p8_seq", (i < q_rp8.size()) ? q_rp8[i] : 32'hDEAD_BEEF, exp_p8[i]);
    end
    check("p8_drained", 32'(u_rp8.u_src.count_r), 32'd0);

    // Mid-stream reset with three words still queued.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; data_in = 32'(10 + i);
      tick();
    end
    en = 1'b0; data_in = 32'd0;
    for (int k = 0; k < 20 && out_rp8 !== 32'd10; k++) tick();
    check("mid_first", out_rp8, 32'd10);
    check("mid_queued", 32'(u_rp8.u_src.count_r), 32'd3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out", out_rp8, 32'd0);
    check("mid_rst_count", 32'(u_rp8.u_src.count_r), 32'd0);
    check("mid_rst_valid", {31'd0, u_rp8.src_valid_s}, 32'd0);
    rst_n = 1'b1;
    q_rp8.delete();
    en = 1'b1; data_in = 32'd9;
    tick();
    en = 1'b0; data_in = 32'd0;
    repeat (12) tick();
    check("mid_after_len", 32'(q_rp8.size()), 32'd1);
    check("mid_after_word", (q_rp8.size() > 0) ? q_rp8[0] : 32'hDEAD_BEEF, 32'd9);
    check("mid_after_out", out_rp8, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
